// File: rtl/unidade_controle_rodadas.sv
// Moore FSM that sequences the round-based memory-game datapath.
// Optional TIMEOUT_EN macro enables the play-timer timeout path.
module unidade_controle_rodadas (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    input  logic       fim_timer,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        inicio_rodada  = 4'h2,
        espera_jogada  = 4'h3,
        registra       = 4'h4,
        comparacao     = 4'h5,
        proxima_jogada = 4'h6,
        proxima_rodada = 4'h7,
        fim_acertou    = 4'hA,
        fim_timeout    = 4'hD,
        fim_errou      = 4'hE
    } state_t;

    state_t state;
    state_t next_state;
    logic   timer_expired;

`ifdef TIMEOUT_EN
    assign timer_expired = fim_timer;
`else
    assign timer_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= inicial;
        else        state <= next_state;
    end

    always_comb begin
        next_state = inicial;
        case (state)
            inicial:        next_state = iniciar ? preparacao : inicial;
            preparacao:     next_state = inicio_rodada;
            inicio_rodada:  next_state = espera_jogada;
            espera_jogada: begin
                if (jogada)             next_state = registra;
                else if (timer_expired) next_state = fim_timeout;
                else                    next_state = espera_jogada;
            end
            registra:       next_state = comparacao;
            comparacao: begin
                if (!igual)                          next_state = fim_errou;
                else if (enderecoIgualLimite && fimL) next_state = fim_acertou;
                else if (enderecoIgualLimite)         next_state = proxima_rodada;
                else                                  next_state = proxima_jogada;
            end
            proxima_jogada: next_state = espera_jogada;
            proxima_rodada: next_state = inicio_rodada;
            fim_acertou:    next_state = iniciar ? preparacao : fim_acertou;
            fim_timeout:    next_state = iniciar ? preparacao : fim_timeout;
            fim_errou:      next_state = iniciar ? preparacao : fim_errou;
            default:        next_state = inicial;
        endcase
    end

    always_comb begin
        zeraC       = 1'b0;
        contaC      = 1'b0;
        zeraL       = 1'b0;
        contaL      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zera_timer  = 1'b0;
        conta_timer = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout     = 1'b0;
        case (state)
            preparacao: begin
                zeraC      = 1'b1;
                zeraL      = 1'b1;
                zeraR      = 1'b1;
                zera_timer = 1'b1;
            end
            inicio_rodada: begin
                zeraC      = 1'b1;
                zera_timer = 1'b1;
            end
`ifdef TIMEOUT_EN
            espera_jogada:  conta_timer = 1'b1;
`endif
            registra:       registraR = 1'b1;
            proxima_jogada: begin
                contaC     = 1'b1;
                zera_timer = 1'b1;
            end
            proxima_rodada: contaL = 1'b1;
            fim_acertou: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            fim_errou: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            fim_timeout: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`else
            fim_timeout:    pronto = 1'b1;
`endif
            default: ;
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed self-checking bench for unidade_controle_rodadas with a small
// address/limit counter model standing in for the datapath (3-round game).
module tb_unidade_controle_rodadas;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b1;
    logic       enderecoIgualLimite;
    logic       fimL;
    logic       fim_timer = 1'b0;
    logic       zeraC, contaC, zeraL, contaL, zeraR, registraR;
    logic       zera_timer, conta_timer, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int passed = 0;
    int total  = 0;
    int addr = 0;
    int lim  = 0;
    int n_c  = 0;
    int n_l  = 0;

    unidade_controle_rodadas dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
        .fim_timer(fim_timer), .zeraC(zeraC), .contaC(contaC), .zeraL(zeraL),
        .contaL(contaL), .zeraR(zeraR), .registraR(registraR),
        .zera_timer(zera_timer), .conta_timer(conta_timer), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath stand-in: limit counter reaching 2 marks the third and last round
    always @(posedge clock) begin
        if (zeraC) addr <= 0; else if (contaC) addr <= addr + 1;
        if (zeraL) lim <= 0;  else if (contaL) lim <= lim + 1;
    end
    assign enderecoIgualLimite = (addr == lim);
    assign fimL = (lim == 2);

    always @(negedge clock) begin
        if (contaC === 1'b1) n_c++;
        if (contaL === 1'b1) n_l++;
    end

    // {zeraC,contaC,zeraL,contaL,zeraR,registraR,zera_timer,conta_timer,pronto,acertou,errou,timeout}
    logic [11:0] outs;
    assign outs = {zeraC, contaC, zeraL, contaL, zeraR, registraR,
                   zera_timer, conta_timer, pronto, acertou, errou, timeout};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] code, input string name);
        int i;
        for (i = 0; i < 50 && db_estado !== code; i++) step();
        total++;
        if (db_estado !== code)
            $display("FAIL %s: wait timed out, db_estado=%h required %h", name, db_estado, code);
        else passed++;
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (db_estado !== 4'h0 || outs !== 12'h000)
            $display("FAIL reset_state: db_estado=%h outs=%h required 0/000", db_estado, outs);
        else passed++;
        step();
        reset = 1'b1;
        step();
        step();
        total++;
        if (db_estado !== 4'h0)
            $display("FAIL idle_without_iniciar: db_estado=%h required 0", db_estado);
        else passed++;
    endtask

    task automatic test_start();
        start_game();
        total++;
        if (db_estado !== 4'h1 || outs !== 12'b1010_1010_0000)
            $display("FAIL start_preparacao: db_estado=%h outs=%h required 1/aa0", db_estado, outs);
        else passed++;
        step();
        total++;
        if (db_estado !== 4'h2 || outs !== 12'b1000_0010_0000)
            $display("FAIL start_inicio_rodada: db_estado=%h outs=%h required 2/820", db_estado, outs);
        else passed++;
        step();
        total++;
`ifdef TIMEOUT_EN
        if (db_estado !== 4'h3 || outs !== 12'b0000_0001_0000)
            $display("FAIL start_espera: db_estado=%h outs=%h required 3/010", db_estado, outs);
`else
        if (db_estado !== 4'h3 || outs !== 12'b0000_0000_0000)
            $display("FAIL start_espera: db_estado=%h outs=%h required 3/000", db_estado, outs);
`endif
        else passed++;
        // iniciar is ignored mid-game
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        total++;
        if (db_estado !== 4'h3)
            $display("FAIL iniciar_ignored: db_estado=%h required 3", db_estado);
        else passed++;
    endtask

    task automatic test_reset_mid_play();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (db_estado !== 4'h0 || outs !== 12'h000)
            $display("FAIL reset_mid_play: db_estado=%h outs=%h required 0/000", db_estado, outs);
        else passed++;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_full_win();
        igual = 1'b1;
        n_c = 0;
        n_l = 0;
        start_game();
        for (int i = 0; i < 200 && db_estado !== 4'hA; i++) begin
            if (db_estado === 4'h3) begin
                jogada = 1'b1;
                step();
                jogada = 1'b0;
                total++;
                if (db_estado !== 4'h4 || registraR !== 1'b1)
                    $display("FAIL win_registra: db_estado=%h registraR=%b required 4/1", db_estado, registraR);
                else passed++;
            end else step();
        end
        total++;
        if (db_estado !== 4'hA || pronto !== 1'b1 || acertou !== 1'b1 || errou !== 1'b0)
            $display("FAIL win_end: db_estado=%h pronto=%b acertou=%b errou=%b required a/1/1/0",
                     db_estado, pronto, acertou, errou);
        else passed++;
        total++;
        if (n_c !== 3) $display("FAIL win_contaC: count=%0d required 3", n_c);
        else passed++;
        total++;
        if (n_l !== 2) $display("FAIL win_contaL: count=%0d required 2", n_l);
        else passed++;
        step();
        step();
        total++;
        if (db_estado !== 4'hA || acertou !== 1'b1)
            $display("FAIL win_hold: db_estado=%h acertou=%b required a/1", db_estado, acertou);
        else passed++;
    endtask

    task automatic test_error();
        start_game();
        wait_state(4'h3, "error_reach_espera");
        igual = 1'b0;
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        step();
        total++;
        if (db_estado !== 4'h5 || outs !== 12'h000)
            $display("FAIL error_comparacao: db_estado=%h outs=%h required 5/000", db_estado, outs);
        else passed++;
        step();
        total++;
        if (db_estado !== 4'hE || pronto !== 1'b1 || errou !== 1'b1 || acertou !== 1'b0)
            $display("FAIL error_end: db_estado=%h pronto=%b errou=%b acertou=%b required e/1/1/0",
                     db_estado, pronto, errou, acertou);
        else passed++;
        igual = 1'b1;
        start_game();
        total++;
        if (db_estado !== 4'h1)
            $display("FAIL error_restart: db_estado=%h required 1", db_estado);
        else passed++;
    endtask

    task automatic test_timeout();
        wait_state(4'h3, "timeout_reach_espera");
`ifdef TIMEOUT_EN
        fim_timer = 1'b1;
        step();
        fim_timer = 1'b0;
        total++;
        if (db_estado !== 4'hD || timeout !== 1'b1 || pronto !== 1'b1)
            $display("FAIL timeout_end: db_estado=%h timeout=%b pronto=%b required d/1/1",
                     db_estado, timeout, pronto);
        else passed++;
        start_game();
        wait_state(4'h3, "timeout_reach_espera2");
        fim_timer = 1'b1;
        jogada = 1'b1;
        step();
        fim_timer = 1'b0;
        jogada = 1'b0;
        total++;
        if (db_estado !== 4'h4)
            $display("FAIL timeout_jogada_priority: db_estado=%h required 4", db_estado);
        else passed++;
`else
        fim_timer = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (db_estado !== 4'h3 || conta_timer !== 1'b0 || timeout !== 1'b0)
                $display("FAIL timeout_disabled: cycle %0d db_estado=%h conta_timer=%b timeout=%b required 3/0/0",
                         i, db_estado, conta_timer, timeout);
            else passed++;
        end
        fim_timer = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_start();
        test_reset_mid_play();
        test_full_win();
        test_error();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
